clock_ctrl: RTL

Front-end controller for the digital clock: debounces the four push-buttons, runs the mode and position state machines, generates the 1 Hz time base, and drives every single-cycle increment pulse consumed by the H:M:S counter block (time and alarm counters), plus mode, position and alarm-enable. It sits between the board buttons and the counter block. The counter block's max-hit flags return here to build the sec→min→hour cascade.

---
 rtl/clock_pkg.sv | 46 ++++
 rtl/btn_debounce.sv | 102 ++++++++++
 rtl/clock_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: mode and position encodings, button indices and default timing.
// These are shared by the clock front-end and the H:M:S counter block.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2,
    POS_RSVD = 2'd3
  } pos_e;

  localparam int CLK_HZ_DEFAULT       = 50_000_000;
  localparam int DEBOUNCE_CYC_DEFAULT = 500_000;

  // Bit positions of the four push-buttons on i_sw
  localparam int BTN_MODE  = 0;
  localparam int BTN_POS   = 1;
  localparam int BTN_INC   = 2;
  localparam int BTN_ALARM = 3;

  // The unused encoding 3 falls back to CLOCK
  function automatic mode_e mode_next(input mode_e m);
    case (m)
      MODE_CLOCK: return MODE_SETUP;
      MODE_SETUP: return MODE_ALARM;
      default:    return MODE_CLOCK;
    endcase
  endfunction

  // The unused encoding 3 falls back to SEC
  function automatic pos_e pos_next(input pos_e p);
    case (p)
      POS_SEC: return POS_MIN;
      POS_MIN: return POS_HOUR;
      default: return POS_SEC;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus stability counter for one active-low
// push-button. It emits a single-cycle press event when a low level is accepted.
// With REPEAT_EN set, holding the button also produces repeat events: the
// first comes REPEAT_FIRST cycles after the press event, then one every
// REPEAT_NEXT cycles for as long as the debounced level stays low.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 500_000,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_FIRST = 50_000_000,
  parameter int REPEAT_NEXT  = 12_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level_q;
  logic          event_q;
  logic [CW-1:0] cnt_q;

  // Bring the raw button into the clk domain; reset to the released level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it differs from the current one for DEBOUNCE_CYC cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      event_q <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q2;
        cnt_q   <= '0;
        event_q <= ~sync_q2;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam int RW = $clog2(REPEAT_FIRST + 1);
      localparam logic [RW-1:0] FIRST_LAST = RW'(REPEAT_FIRST - 1);
      localparam logic [RW-1:0] NEXT_LAST  = RW'(REPEAT_NEXT - 1);
      localparam logic [RW-1:0] RPT_ONE    = RW'(1);

      logic [RW-1:0] rcnt_q;
      logic          first_q;
      logic          rpt_q;

      // Count hold time since the press event and emit repeat events while still held
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rcnt_q  <= '0;
          first_q <= 1'b1;
          rpt_q   <= 1'b0;
        end else begin
          rpt_q <= 1'b0;
          if (event_q) begin
            rcnt_q  <= RPT_ONE;
            first_q <= 1'b1;
          end else if (!level_q) begin
            if ((first_q && rcnt_q == FIRST_LAST) || (!first_q && rcnt_q == NEXT_LAST)) begin
              rpt_q   <= 1'b1;
              rcnt_q  <= '0;
              first_q <= 1'b0;
            end else begin
              rcnt_q <= rcnt_q + RPT_ONE;
            end
          end else begin
            rcnt_q  <= '0;
            first_q <= 1'b1;
          end
        end
      end

      assign press = event_q | rpt_q;
    end else begin : g_no_repeat
      assign press = event_q;
    end
  endgenerate

endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: button front-end, mode/position FSM, 1 Hz time base and routing
// of the increment pulses to the time and alarm counters.
// Optional feature macro: CLOCK_CTRL_AUTOREPEAT_EN (increment auto-repeat while held).
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = CLK_HZ_DEFAULT,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_sw,
  input  logic       i_max_hit_sec,
  input  logic       i_max_hit_min,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_clk,
  output logic       o_min_clk,
  output logic       o_hour_clk,
  output logic       o_alarm_sec_clk,
  output logic       o_alarm_min_clk,
  output logic       o_alarm_hour_clk,
  output logic       o_alarm_en
);

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
  localparam bit INC_REPEAT = 1'b1;
`else
  localparam bit INC_REPEAT = 1'b0;
`endif

  localparam int TW = $clog2(CLK_HZ);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  logic [3:0]    btn_evt;
  logic [TW-1:0] tick_cnt_q;
  logic          tick_now;
  logic          hit_sec_q1, hit_sec_q2;
  logic          hit_min_q1, hit_min_q2;
  logic          sec_rise, min_rise;
  logic          cascade_on;
  logic          mode_evt, pos_evt, inc_evt, alarm_evt;
  mode_e         mode_q;
  pos_e          pos_q;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_EN    ((i == BTN_INC) && INC_REPEAT),
      .REPEAT_FIRST (CLK_HZ),
      .REPEAT_NEXT  (CLK_HZ / 4)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (i_sw[i]),
      .press (btn_evt[i])
    );
  end

  assign mode_evt  = btn_evt[BTN_MODE];
  assign pos_evt   = btn_evt[BTN_POS];
  assign inc_evt   = btn_evt[BTN_INC];
  assign alarm_evt = btn_evt[BTN_ALARM];

  assign tick_now   = (mode_q != MODE_SETUP) && (tick_cnt_q == TICK_LAST);
  assign cascade_on = (mode_q != MODE_SETUP);
  assign sec_rise   = hit_sec_q1 & ~hit_sec_q2;
  assign min_rise   = hit_min_q1 & ~hit_min_q2;

  // 1 Hz time base; held at zero during SETUP so the first tick after leaving it is a full period away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (mode_q == MODE_SETUP || tick_cnt_q == TICK_LAST) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TICK_ONE;
    end
  end

  // Capture the counter wrap flags and keep their previous value for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_sec_q1 <= 1'b0;
      hit_sec_q2 <= 1'b0;
      hit_min_q1 <= 1'b0;
      hit_min_q2 <= 1'b0;
    end else begin
      hit_sec_q1 <= i_max_hit_sec;
      hit_sec_q2 <= hit_sec_q1;
      hit_min_q1 <= i_max_hit_min;
      hit_min_q2 <= hit_min_q1;
    end
  end

  // Mode/position FSM and registered pulse routing; a mode press drops a same-cycle position or increment press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q           <= MODE_CLOCK;
      pos_q            <= POS_SEC;
      o_alarm_en       <= 1'b0;
      o_sec_clk        <= 1'b0;
      o_min_clk        <= 1'b0;
      o_hour_clk       <= 1'b0;
      o_alarm_sec_clk  <= 1'b0;
      o_alarm_min_clk  <= 1'b0;
      o_alarm_hour_clk <= 1'b0;
    end else begin
      o_sec_clk        <= tick_now;
      o_min_clk        <= cascade_on & sec_rise;
      o_hour_clk       <= cascade_on & min_rise;
      o_alarm_sec_clk  <= 1'b0;
      o_alarm_min_clk  <= 1'b0;
      o_alarm_hour_clk <= 1'b0;

      if (alarm_evt) begin
        o_alarm_en <= ~o_alarm_en;
      end

      if (mode_q == MODE_RSVD) begin
        mode_q <= MODE_CLOCK;
        pos_q  <= POS_SEC;
      end else if (mode_evt) begin
        mode_q <= mode_next(mode_q);
        pos_q  <= POS_SEC;
      end else begin
        if (inc_evt) begin
          if (mode_q == MODE_SETUP) begin
            case (pos_q)
              POS_SEC:  o_sec_clk  <= 1'b1;
              POS_MIN:  o_min_clk  <= 1'b1;
              POS_HOUR: o_hour_clk <= 1'b1;
              default:  ;
            endcase
          end else if (mode_q == MODE_ALARM) begin
            case (pos_q)
              POS_SEC:  o_alarm_sec_clk  <= 1'b1;
              POS_MIN:  o_alarm_min_clk  <= 1'b1;
              POS_HOUR: o_alarm_hour_clk <= 1'b1;
              default:  ;
            endcase
          end
        end
        if (pos_q == POS_RSVD) begin
          pos_q <= POS_SEC;
        end else if (pos_evt && mode_q != MODE_CLOCK) begin
          pos_q <= pos_next(pos_q);
        end
      end
    end
  end

  assign o_mode     = mode_q;
  assign o_position = pos_q;

endmodule
